// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD magnitude comparator.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {IDLE, CMP} state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/bcd_digit_cmp.sv
// Combinational single-digit BCD comparator with a non-BCD flag.
module bcd_digit_cmp
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               lt,
  output logic               eq,
  output logic               gt,
  output logic               invalid
);

  always_comb begin
    lt      = (a < b);
    eq      = (a == b);
    gt      = (a > b);
    invalid = (a > BCD_MAX) || (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_comparator_seq.sv
// Digit-serial BCD magnitude comparator, MSD first, with sign-magnitude and early-exit options.
module bcd_comparator_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic                         a_sign,
  input  logic                         b_sign,
  input  logic [4*DIGITS-1:0]          a,
  input  logic [4*DIGITS-1:0]          b,
  output logic                         busy,
  output logic                         done,
  output logic                         lt,
  output logic                         eq,
  output logic                         gt,
  output logic                         invalid,
  output logic [$clog2(DIGITS+1)-1:0]  digits_used
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIGITS+1);

  state_t                   state;
  logic                     first;
  logic [4*DIGITS-1:0]      cap_a;
  logic [4*DIGITS-1:0]      cap_b;
  logic                     cap_sm;
  logic                     cap_as;
  logic                     cap_bs;
  logic [IW-1:0]            index;
  logic [CW-1:0]            count;
  cmp_result_t              held;
  logic                     held_valid;

  logic [DIGIT_W-1:0]       da;
  logic [DIGIT_W-1:0]       db;
  logic                     d_lt;
  logic                     d_eq;
  logic                     d_gt;
  logic                     d_inv;
  cmp_result_t              dig;
  cmp_result_t              raw;
  cmp_result_t              fin;
  logic [DIGITS-1:0]        dig_bad;
  logic                     word_invalid;
  logic                     sign_decided;
  logic                     mag_zero;

  always_comb begin
    da = cap_a[DIGIT_W*int'(index) +: DIGIT_W];
    db = cap_b[DIGIT_W*int'(index) +: DIGIT_W];
  end

  bcd_digit_cmp u_digit_cmp (
    .a       (da),
    .b       (db),
    .lt      (d_lt),
    .eq      (d_eq),
    .gt      (d_gt),
    .invalid (d_inv)
  );

  for (genvar g = 0; g < DIGITS; g++) begin : g_bad
    assign dig_bad[g] = (cap_a[DIGIT_W*g +: DIGIT_W] > BCD_MAX) ||
                        (cap_b[DIGIT_W*g +: DIGIT_W] > BCD_MAX);
  end

  // The first unequal digit wins; with both operands negative the magnitude order flips.
  always_comb begin
    dig          = '{lt: d_lt, eq: d_eq, gt: d_gt};
    raw          = held_valid ? held : dig;
    fin          = raw;
    if (cap_sm && cap_as && cap_bs) begin
      fin.lt = raw.gt;
      fin.gt = raw.lt;
    end
    word_invalid = (|dig_bad) || d_inv;
    sign_decided = cap_sm && (cap_as != cap_bs);
    mag_zero     = (cap_a == '0) && (cap_b == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      first       <= 1'b0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_sm      <= 1'b0;
      cap_as      <= 1'b0;
      cap_bs      <= 1'b0;
      index       <= '0;
      count       <= '0;
      held        <= '0;
      held_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      invalid     <= 1'b0;
      digits_used <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cap_a       <= a;
            cap_b       <= b;
            cap_sm      <= signed_mode;
            cap_as      <= a_sign;
            cap_bs      <= b_sign;
            index       <= IW'(DIGITS-1);
            count       <= '0;
            held        <= '0;
            held_valid  <= 1'b0;
            first       <= 1'b1;
            lt          <= 1'b0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            invalid     <= 1'b0;
            digits_used <= '0;
            busy        <= 1'b1;
            state       <= CMP;
          end
        end
        CMP: begin
          first <= 1'b0;
          if (first && word_invalid) begin
            invalid <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (first && sign_decided) begin
            if (mag_zero) begin
              eq <= 1'b1;
            end else begin
              gt <= cap_bs;
              lt <= cap_as;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
            if ((!d_eq && (EARLY_EXIT != 0)) || (index == '0)) begin
              lt          <= fin.lt;
              eq          <= fin.eq;
              gt          <= fin.gt;
              digits_used <= count + CW'(1);
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              if (!d_eq && !held_valid) begin
                held       <= dig;
                held_valid <= 1'b1;
              end
              index <= index - IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_comparator_seq.sv
// Self-checking bench: early-exit and constant-latency instances driven in parallel.
module tb_bcd_comparator_seq;
  localparam int D = 3;

  typedef struct {
    int lt, eq, gt, inv, used, lat;
  } res_t;

  typedef struct {
    logic [4*D-1:0] a, b;
    logic           sm, as, bs;
    res_t           ee, ne;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic           a_sign = 1'b0;
  logic           b_sign = 1'b0;
  logic [4*D-1:0] a = '0;
  logic [4*D-1:0] b = '0;

  logic busy_e, done_e, lt_e, eq_e, gt_e, inv_e;
  logic busy_n, done_n, lt_n, eq_n, gt_n, inv_n;
  logic [$clog2(D+1)-1:0] used_e, used_n;

  int passed = 0;
  int total  = 0;

  bcd_comparator_seq #(.DIGITS(D), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a_sign(a_sign), .b_sign(b_sign), .a(a), .b(b),
    .busy(busy_e), .done(done_e), .lt(lt_e), .eq(eq_e), .gt(gt_e),
    .invalid(inv_e), .digits_used(used_e)
  );

  bcd_comparator_seq #(.DIGITS(D), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a_sign(a_sign), .b_sign(b_sign), .a(a), .b(b),
    .busy(busy_n), .done(done_n), .lt(lt_n), .eq(eq_n), .gt(gt_n),
    .invalid(inv_n), .digits_used(used_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: decimal values compared arithmetically, scan length from first differing digit.
  function automatic res_t model(input logic [4*D-1:0] va, input logic [4*D-1:0] vb,
                                 input logic sm, input logic as, input logic bs, input bit ee);
    res_t r;
    int da, db, ma, mb, w, firstdiff, tmp;
    r = '{default: 0};
    ma = 0; mb = 0; w = 1; firstdiff = 0;
    for (int i = 0; i < D; i++) begin
      da = int'(va[4*i +: 4]);
      db = int'(vb[4*i +: 4]);
      if (da > 9 || db > 9) r.inv = 1;
      if (da != db) firstdiff = D - i;
      ma += da * w;
      mb += db * w;
      w  *= 10;
    end
    r.lat = 1;
    if (r.inv == 1) return r;
    if (sm && (as != bs)) begin
      if (ma == 0 && mb == 0) r.eq = 1;
      else begin
        r.gt = int'(bs);
        r.lt = int'(as);
      end
      return r;
    end
    r.lt = (ma < mb) ? 1 : 0;
    r.gt = (ma > mb) ? 1 : 0;
    r.eq = (ma == mb) ? 1 : 0;
    if (sm && as && bs) begin
      tmp = r.lt; r.lt = r.gt; r.gt = tmp;
    end
    r.used = (ee && firstdiff > 0) ? firstdiff : D;
    r.lat  = r.used;
    return r;
  endfunction

  task automatic run(input string tag, input logic [4*D-1:0] va, input logic [4*D-1:0] vb,
                     input logic vsm, input logic vas, input logic vbs,
                     input res_t xe, input res_t xn);
    int le, ln, ce, cn;
    le = 0; ln = 0; ce = 0; cn = 0;
    @(negedge clk);
    a = va; b = vb; signed_mode = vsm; a_sign = vas; b_sign = vbs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " ee busy"}, int'(busy_e), 1);
    check({tag, " ne busy"}, int'(busy_n), 1);
    for (int c = 1; c <= D + 3; c++) begin
      @(posedge clk); #1;
      if (done_e) begin ce++; if (le == 0) le = c; end
      if (done_n) begin cn++; if (ln == 0) ln = c; end
    end
    check({tag, " ee lat"},   le, xe.lat);
    check({tag, " ee pulses"}, ce, 1);
    check({tag, " ee lt"},    int'(lt_e),   xe.lt);
    check({tag, " ee eq"},    int'(eq_e),   xe.eq);
    check({tag, " ee gt"},    int'(gt_e),   xe.gt);
    check({tag, " ee inv"},   int'(inv_e),  xe.inv);
    check({tag, " ee used"},  int'(used_e), xe.used);
    check({tag, " ne lat"},   ln, xn.lat);
    check({tag, " ne pulses"}, cn, 1);
    check({tag, " ne lt"},    int'(lt_n),   xn.lt);
    check({tag, " ne eq"},    int'(eq_n),   xn.eq);
    check({tag, " ne gt"},    int'(gt_n),   xn.gt);
    check({tag, " ne inv"},   int'(inv_n),  xn.inv);
    check({tag, " ne used"},  int'(used_n), xn.used);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ee outs"}, int'({busy_e, done_e, lt_e, eq_e, gt_e, inv_e}), 0);
    check({tag, " ee used"}, int'(used_e), 0);
    check({tag, " ne outs"}, int'({busy_n, done_n, lt_n, eq_n, gt_n, inv_n}), 0);
    check({tag, " ne used"}, int'(used_n), 0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{12'h512, 12'h498, 1'b0, 1'b0, 1'b0, '{0,0,1,0,1,1}, '{0,0,1,0,3,3}};
    tbl[1] = '{12'h347, 12'h347, 1'b0, 1'b0, 1'b0, '{0,1,0,0,3,3}, '{0,1,0,0,3,3}};
    tbl[2] = '{12'h005, 12'h900, 1'b1, 1'b0, 1'b1, '{0,0,1,0,0,1}, '{0,0,1,0,0,1}};
    tbl[3] = '{12'h000, 12'h000, 1'b1, 1'b1, 1'b0, '{0,1,0,0,0,1}, '{0,1,0,0,0,1}};
    tbl[4] = '{12'h120, 12'h130, 1'b1, 1'b1, 1'b1, '{0,0,1,0,2,2}, '{0,0,1,0,3,3}};
    tbl[5] = '{12'h3A1, 12'h100, 1'b0, 1'b0, 1'b0, '{0,0,0,1,0,1}, '{0,0,0,1,0,1}};
    tbl[6] = '{12'h100, 12'h109, 1'b0, 1'b0, 1'b0, '{1,0,0,0,3,3}, '{1,0,0,0,3,3}};
    tbl[7] = '{12'h200, 12'h300, 1'b1, 1'b0, 1'b0, '{1,0,0,0,1,1}, '{1,0,0,0,3,3}};
    tbl[8] = '{12'h00F, 12'h000, 1'b1, 1'b1, 1'b0, '{0,0,0,1,0,1}, '{0,0,0,1,0,1}};
    tbl[9] = '{12'h999, 12'h998, 1'b0, 1'b1, 1'b1, '{0,0,1,0,3,3}, '{0,0,1,0,3,3}};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].as, tbl[i].bs,
          tbl[i].ee, tbl[i].ne);

    for (int n = 0; n < 40; n++) begin
      logic [4*D-1:0] va, vb;
      logic vsm, vas, vbs;
      for (int i = 0; i < D; i++) begin
        va[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        vb[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      case ($urandom_range(0, 3))
        0: vb = va;
        1: begin vb = va; vb[3:0] = 4'($urandom_range(0, 9)); end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin va = '0; vb = '0; end
      vsm = 1'($urandom_range(0, 1));
      vas = 1'($urandom_range(0, 1));
      vbs = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d", n), va, vb, vsm, vas, vbs,
          model(va, vb, vsm, vas, vbs, 1'b1), model(va, vb, vsm, vas, vbs, 1'b0));
    end

    // Start held high: each instance re-accepts in its done cycle.
    @(negedge clk);
    a = 12'h512; b = 12'h498; signed_mode = 1'b0; start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("b2b ee done c%0d", c), int'(done_e), c % 2);
      check($sformatf("b2b ne done c%0d", c), int'(done_n), (c % 4 == 3) ? 1 : 0);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Start pulses while busy are ignored.
    begin
      int ce, cn;
      ce = 0; cn = 0;
      @(negedge clk);
      a = 12'h347; b = 12'h347; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 6; c++) begin
        start = (c <= 2) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        if (done_e) ce++;
        if (done_n) cn++;
      end
      start = 1'b0;
      check("busy-start ee pulses", ce, 1);
      check("busy-start ne pulses", cn, 1);
    end

    // Reset in the second CMP cycle aborts with no later done.
    begin
      int ce, cn;
      ce = 0; cn = 0;
      @(negedge clk);
      a = 12'h347; b = 12'h347; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_zero("abort");
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (done_e) ce++;
        if (done_n) cn++;
      end
      check("abort ee pulses", ce, 0);
      check("abort ne pulses", cn, 0);
      check("abort ee busy", int'(busy_e), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
